// File: rtl/uart_loopback_top.sv
// UART traffic block: incrementing-pattern 8N1 transmitter plus receiver that checks the same sequence.
// Define UART_FLOW_CTRL_EN to add RTS/CTS flow control (sig_rts_rx / sig_cts_tx).
module uart_loopback_top #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sig_rx,
  output logic       sig_tx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
`ifdef UART_FLOW_CTRL_EN
  ,
  input  logic       sig_rts_rx,
  output logic       sig_cts_tx
`endif
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [IW-1:0] tx_idx, tx_idx_d;
  logic [7:0]    tx_gen, tx_gen_d;
  logic          tx_line_d;
  logic          tx_bit_end;
  logic          tx_go;

`ifdef UART_FLOW_CTRL_EN
  logic rts_s1, rts_s2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rts_s1 <= 1'b1;
      rts_s2 <= 1'b1;
    end else begin
      rts_s1 <= sig_rts_rx;
      rts_s2 <= rts_s1;
    end
  end

  assign tx_go = ~rts_s2;
`else
  assign tx_go = 1'b1;
`endif

  assign tx_bit_end = (tx_cnt == BIT_LAST);

  // Idle timer saturates at BIT_LAST; leaving STOP preloads it so the next frame waits one cycle.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_idx_d   = tx_idx;
    tx_gen_d   = tx_gen;
    tx_line_d  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (tx_bit_end && tx_go) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
        end else if (!tx_bit_end) begin
          tx_cnt_d = tx_cnt + CW'(1);
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx == IDX_LAST) tx_state_d = TX_STOP;
          else                    tx_idx_d   = tx_idx + IW'(1);
        end else begin
          tx_cnt_d = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = BIT_LAST;
          tx_gen_d   = tx_gen + 8'd1;
        end else begin
          tx_cnt_d = tx_cnt + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_gen[tx_idx_d];
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_gen   <= 8'h00;
      sig_tx   <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_idx   <= tx_idx_d;
      tx_gen   <= tx_gen_d;
      sig_tx   <= tx_line_d;
    end
  end

  // ---------------- receiver and checker ----------------
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 rx_fall;
  rx_state_t            rx_state, rx_state_d;
  logic [CW-1:0]        rx_cnt, rx_cnt_d;
  logic [IW-1:0]        rx_idx, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic [7:0]           rx_exp, rx_exp_d;
  logic [7:0]           rx_byte_d;
  logic                 rx_valid_d, rx_error_d;
  logic [7:0]           rx_word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= sig_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // A held-low line never produces a second 1->0 edge, so a break yields one framing error.
  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_word = 8'(rx_shift);

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_idx_d   = rx_idx;
    rx_shift_d = rx_shift;
    rx_exp_d   = rx_exp;
    rx_byte_d  = rx_byte;
    rx_valid_d = 1'b0;
    rx_error_d = rx_error;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          if (rx_s2) rx_state_d = RX_IDLE;
          else       rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_idx == IDX_LAST) rx_state_d = RX_STOP;
          else                    rx_idx_d   = rx_idx + IW'(1);
        end else begin
          rx_cnt_d = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
          if (rx_s2) begin
            rx_byte_d  = rx_word;
            rx_valid_d = 1'b1;
            rx_exp_d   = rx_word + 8'd1;
            if (rx_word != rx_exp) rx_error_d = 1'b1;
          end else begin
            rx_error_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_exp   <= 8'h00;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_idx   <= rx_idx_d;
      rx_shift <= rx_shift_d;
      rx_exp   <= rx_exp_d;
      rx_byte  <= rx_byte_d;
      rx_valid <= rx_valid_d;
      rx_error <= rx_error_d;
    end
  end

`ifdef UART_FLOW_CTRL_EN
  // Clear-to-send tracks the receiver being idle, aligned with the registered RX state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sig_cts_tx <= 1'b1;
    else        sig_cts_tx <= (rx_state_d != RX_IDLE);
  end
`endif

endmodule

// File: tb/tb_uart_loopback_top.sv
// Bench for uart_loopback_top: loopback pattern run, then injected frames against a byte-level model.
// Flow-control steps are compiled only when UART_FLOW_CTRL_EN is defined.
`timescale 1ns/1ps
module tb_uart_loopback_top;
  localparam int unsigned DIV = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sig_rx, sig_tx, rx_valid, rx_error;
  logic [7:0] rx_byte;
  logic       inject = 1'b0;
  logic       drv = 1'b1;

  assign sig_rx = inject ? drv : sig_tx;

`ifdef UART_FLOW_CTRL_EN
  logic rts = 1'b0;
  logic cts;
`endif

  uart_loopback_top #(.CLK_DIV(DIV), .DATA_BITS(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .sig_rx   (sig_rx),
    .sig_tx   (sig_tx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_error (rx_error)
`ifdef UART_FLOW_CTRL_EN
    ,
    .sig_rts_rx (rts),
    .sig_cts_tx (cts)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          vcnt = 0;
  logic [7:0]  vbyte = 8'h00;
  int unsigned vtime = 0;

  // Byte-level reference: next expected byte and sticky error flag.
  logic [7:0]  m_exp = 8'h00;
  bit          m_err = 1'b0;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    if (rx_valid) begin
      vcnt++;
      vbyte = rx_byte;
      vtime = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int prev, input int budget, output bit ok);
    int n = 0;
    while (vcnt == prev && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = (vcnt != prev);
  endtask

  task automatic do_reset();
    @(negedge clock);
    drv   = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_sig_tx", 32'(sig_tx), 32'd1);
    chk("rst_rx_byte", 32'(rx_byte), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_error", 32'(rx_error), 32'd0);
`ifdef UART_FLOW_CTRL_EN
    chk("rst_cts", 32'(cts), 32'd1);
`endif
    repeat (3) @(negedge clock);
    reset = 1'b1;
    m_exp = 8'h00;
    m_err = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    drv = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      drv = b[i];
      repeat (DIV) @(negedge clock);
    end
    drv = stop;
    repeat (DIV) @(negedge clock);
    drv = 1'b1;
  endtask

  task automatic send_check(input logic [7:0] b, input bit stop, input string tag);
    int prev = vcnt;
    send_frame(b, stop);
    repeat (2 * DIV) @(negedge clock);
    if (stop) begin
      if (b != m_exp) m_err = 1'b1;
      m_exp = b + 8'd1;
      chk({tag, "_valid"}, 32'(vcnt - prev), 32'd1);
      chk({tag, "_byte"}, 32'(vbyte), 32'(b));
    end else begin
      m_err = 1'b1;
      chk({tag, "_novalid"}, 32'(vcnt - prev), 32'd0);
    end
    chk({tag, "_err"}, 32'(rx_error), 32'(m_err));
  endtask

  initial begin
    bit          ok;
    int          n;
    int          prev;
    int unsigned t0, tprev, lat;
    logic [7:0]  b;
    bit          stop;

    // Reset values and first start bit in loopback.
    do_reset_first: begin
      repeat (2) @(negedge clock);
      #1;
      chk("rst_sig_tx", 32'(sig_tx), 32'd1);
      chk("rst_rx_byte", 32'(rx_byte), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_error", 32'(rx_error), 32'd0);
`ifdef UART_FLOW_CTRL_EN
      chk("rst_cts", 32'(cts), 32'd1);
`endif
      @(negedge clock);
      reset = 1'b1;
    end

    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (sig_tx && n < 100);
    chk("first_start", 32'(n), 32'd16);
    t0    = cyc;
    tprev = t0;

    // 257 loopback frames: pattern wraps, spacing is one frame period.
    for (int k = 0; k < 257; k++) begin
      prev = vcnt;
      wait_valid(prev, 400, ok);
      chk("lb_valid", 32'(ok), 32'd1);
      chk("lb_byte", 32'(vbyte), 32'(k % 256));
      if (k == 0) begin
        lat = vtime - t0;
        chk("lb_latency", 32'(lat >= 154 && lat <= 156), 32'd1);
      end else begin
        chk("lb_spacing", 32'(vtime - tprev), 32'd161);
      end
      tprev = vtime;
      chk("lb_err", 32'(rx_error), 32'd0);
    end

    // Switch to injected line right after a stop sample, while the line is high.
    drv    = 1'b1;
    inject = 1'b1;
    repeat (3 * DIV) @(negedge clock);

    // Short low pulse is rejected as a glitch.
    prev = vcnt;
    drv  = 1'b0;
    repeat (4) @(negedge clock);
    drv = 1'b1;
    repeat (20 * DIV) @(negedge clock);
    chk("glitch_novalid", 32'(vcnt - prev), 32'd0);
    chk("glitch_err", 32'(rx_error), 32'd0);

    // Pattern mismatch is sticky and the checker resyncs.
    do_reset();
    send_check(8'h00, 1'b1, "seq0");
    send_check(8'h05, 1'b1, "seq5");
    send_check(8'h06, 1'b1, "seq6");
    send_check(8'h07, 1'b1, "seq7");

    // Framing error: no valid, sticky through later good frames.
    do_reset();
    send_check(8'h00, 1'b1, "fr_ok");
    send_check(8'($urandom), 1'b0, "fr_bad");
    send_check(m_exp, 1'b1, "fr_after");

    // Break: one framing error, then reception resumes once the line idles.
    do_reset();
    prev = vcnt;
    drv  = 1'b0;
    repeat (30 * DIV) @(negedge clock);
    chk("brk_novalid", 32'(vcnt - prev), 32'd0);
    chk("brk_err", 32'(rx_error), 32'd1);
    drv = 1'b1;
    repeat (2 * DIV) @(negedge clock);
    m_err = 1'b1;
    send_check(m_exp, 1'b1, "brk_after");

    // Random frames against the model.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, DIV)) @(negedge clock);
      b    = ($urandom_range(0, 1) == 0) ? m_exp : 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_check(b, stop, "rnd");
    end

`ifdef UART_FLOW_CTRL_EN
    // Flow control: held, released, then raised mid-frame.
    rts = 1'b1;
    do_reset();
    chk("cts_idle", 32'(cts), 32'd0);
    n = 0;
    repeat (400) begin
      @(negedge clock);
      if (!sig_tx) n++;
    end
    chk("rts_hold", 32'(n), 32'd0);
    rts = 1'b0;
    n   = 0;
    do begin
      @(negedge clock);
      n++;
    end while (sig_tx && n < 50);
    chk("rts_start", 32'(n >= 1 && n <= 3), 32'd1);
    n = 1;
    repeat (40) begin
      @(negedge clock);
      if (!sig_tx) n++;
    end
    rts = 1'b1;
    repeat (460) begin
      @(negedge clock);
      if (!sig_tx) n++;
    end
    chk("rts_frame_lows", 32'(n), 32'd144);
    chk("rts_held_idle", 32'(sig_tx), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_loopback_top.md
Name: uart_loopback_top

Overview:
- Self-contained UART traffic block: an internal pattern generator drives a UART transmitter and a UART receiver checks incoming bytes against the expected sequence.
- Pattern: 0x00..0xFF incrementing, wrapping.
- Used at chip/board top level; in loopback, sig_tx is wired externally to sig_rx.
- Format 8N1, LSB first.

Parameters:
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200 baud); legal ≥ 4.
- DATA_BITS, 8, data bits per frame; fixed 8 for the pattern checker.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sig_rx  input  1  serial receive line, idle high, asynchronous to clock.
- sig_tx  output  1  serial transmit line, idle high.
- rx_byte  output  8  last byte received with a good stop bit.
- rx_valid  output  1  one-cycle pulse when rx_byte updates.
- rx_error  output  1  sticky: framing error or pattern mismatch seen since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: sig_tx=1, rx_byte=0x00, rx_valid=0, rx_error=0.
  - TX and RX FSMs go to IDLE.
  - Generator byte and expected byte both = 0x00.
  - Reset mid-frame aborts immediately; sig_tx returns high in the same reset assertion.
- TX FSM, states IDLE→START→DATA→STOP→IDLE:
  - Each state bit lasts exactly CLK_DIV cycles, counted by a bit-timer.
  - IDLE: sig_tx=1. After reset release, the first frame starts on the first clock edge after one full idle bit time (CLK_DIV cycles).
  - START: sig_tx=0.
  - DATA: sends the generator byte bit0 first, 8 bits.
  - STOP: sig_tx=1 for CLK_DIV cycles.
  - After STOP, the generator byte increments (0xFF wraps to 0x00). The FSM passes through IDLE for one cycle, then starts the next frame.
  - Frame period = 10*CLK_DIV+1 cycles.
- RX path:
  - sig_rx passes through a 2-flop synchronizer; all RX logic uses the synchronized signal.
  - IDLE: waits for a synchronized falling edge (1→0).
  - START: waits CLK_DIV/2 (integer division) cycles to mid-bit. If the line is sampled high there, treat it as a glitch and return to IDLE with no error.
  - DATA: samples 8 bits at CLK_DIV-cycle intervals from mid-start, shifting LSB first.
  - STOP: samples CLK_DIV cycles after the last data sample.
    - Stop=1: rx_byte ← shifted byte; rx_valid=1 for exactly one cycle; return to IDLE and rearm edge detection immediately.
    - Stop=0: set rx_error; no rx_valid; return to IDLE and wait for the line to go high before rearming.
- Checker, on each rx_valid:
  - rx_byte compared to the expected byte; mismatch sets rx_error.
  - Expected byte then becomes rx_byte+1 mod 256, regardless of match (resync).
  - rx_error clears only on reset.
- Latency, loopback: rx_valid pulses 2 (synchronizer) + 1 (edge detect) + CLK_DIV/2 + 9*CLK_DIV cycles after the TX start bit begins, ±1 cycle.
- Simultaneous events: TX and RX are independent; RX receiving never stalls TX.
- A break (line held low) produces exactly one framing error, then RX waits for idle.

Optional Feature:
- Macro UART_FLOW_CTRL_EN.
- When defined, adds two ports:
  - sig_rts_rx, input, 1 bit: peer permission, active-low.
  - sig_cts_tx, output, 1 bit: reset value 1.
- Flow control:
  - TX leaves IDLE only while synchronized sig_rts_rx=0. A frame already started always completes.
  - sig_cts_tx=0 whenever the RX FSM is in IDLE and reset is released, otherwise 1.
- When undefined: the ports are absent and TX transmits continuously.

Test Plan:
- Reset, CLK_DIV=16, loopback sig_rx=sig_tx:
  - sig_tx=1 and all outputs 0 during reset.
  - First start bit begins 16 cycles after release.
  - rx_valid pulses with rx_byte=0x00, then 0x01, 0x02…; rx_error stays 0.
- Run 257 frames in loopback → rx_byte sequence wraps 0xFF→0x00; rx_error=0; frame spacing 161 cycles.
- Drive sig_rx with a byte whose stop bit is 0 → no rx_valid; rx_error=1 and remains 1 through later good frames.
- Drive sig_rx with a low pulse of 4 cycles (CLK_DIV=16) → no rx_valid, rx_error=0 (glitch rejected).
- Drive sig_rx with 0x00 then 0x05 → rx_error=1 on the second byte. A following 0x06 gives rx_valid and keeps rx_error=1 (sticky); the checker resyncs to expect 0x07.
- With UART_FLOW_CTRL_EN:
  - Hold sig_rts_rx=1 → sig_tx stays 1 indefinitely.
  - Drop sig_rts_rx to 0 → a start bit appears within 3 cycles plus the remaining idle bit.
  - Raise sig_rts_rx mid-frame → the frame completes and the next frame is held.
